logic_unit_arbiter: RTL

//   Shares one bitwise logic unit between NUM_REQ requesters.
//   - Supported ops: AND/OR/XOR/NOT-A/NOT-B/NAND/NOR/XNOR.
//   - Round-robin arbitration; valid/ready handshake on request and response.
//   - Registered result tagged with the winning requester's id.
//   - Sits between client blocks and the shared gate datapath; one op in flight at a time.

---
 rtl/logic_unit_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NUM_REQ requesters.
// Optional LOGIC_ARB_STATS_EN adds a saturating completed-response counter (op_count_out).
//
// state | meaning
// IDLE  | searching for a round-robin winner, req_ready_out strobes the grant
// EXEC  | captured op evaluated, result and id registered
// RESP  | rsp_valid_out held until rsp_ready_in
module logic_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [3*NUM_REQ-1:0]     req_op_in,
    input  logic [WIDTH*NUM_REQ-1:0] req_a_in,
    input  logic [WIDTH*NUM_REQ-1:0] req_b_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [ID_W-1:0]          rsp_id_out,
    output logic [WIDTH-1:0]         rsp_data_out,
    output logic                     busy_out
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [15:0]              op_count_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_last_grant;
    logic [ID_W-1:0]   r_id;
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;

    logic              w_hi_any;
    logic              w_lo_any;
    logic [ID_W-1:0]   w_hi_idx;
    logic [ID_W-1:0]   w_lo_idx;
    logic              w_any;
    logic [ID_W-1:0]   w_winner;
    logic [NUM_REQ-1:0] w_onehot;
    logic [2:0]        w_sel_op;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    logic              w_accept;
    logic              w_rsp_done;

    function automatic logic [WIDTH-1:0] f_logic(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        case (op)
            3'd0:    res = a & b;
            3'd1:    res = a | b;
            3'd2:    res = a ^ b;
            3'd3:    res = ~a;
            3'd4:    res = ~b;
            3'd5:    res = ~(a & b);
            3'd6:    res = ~(a | b);
            default: res = ~(a ^ b);
        endcase
        return res;
    endfunction

    // Requesters above last_grant take precedence; otherwise wrap to the lowest index.
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_in[i]) begin
                if (i > int'(r_last_grant)) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = ID_W'(i);
                end else begin
                    w_lo_any = 1'b1;
                    w_lo_idx = ID_W'(i);
                end
            end
        end
        w_any    = w_hi_any | w_lo_any;
        w_winner = w_hi_any ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_onehot = '0;
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_winner) begin
                w_onehot[i] = 1'b1;
                w_sel_op    = req_op_in[3*i +: 3];
                w_sel_a     = req_a_in[WIDTH*i +: WIDTH];
                w_sel_b     = req_b_in[WIDTH*i +: WIDTH];
            end
        end
    end

    // Gated by reset so no grant strobe escapes while reset is held.
    assign w_accept      = (r_state == ST_IDLE) && w_any && rst_n_in;
    assign req_ready_out = w_accept ? w_onehot : '0;
    assign w_rsp_done    = (r_state == ST_RESP) && rsp_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_id          <= '0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            rsp_valid_out <= 1'b0;
            rsp_id_out    <= '0;
            rsp_data_out  <= '0;
            busy_out      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id         <= w_winner;
                        r_op         <= w_sel_op;
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_last_grant <= w_winner;
                        busy_out     <= 1'b1;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_out  <= f_logic(r_op, r_a, r_b);
                    rsp_id_out    <= r_id;
                    rsp_valid_out <= 1'b1;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        busy_out      <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_out <= 1'b0;
                    busy_out      <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_op_count <= '0;
        end else if (w_rsp_done && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count_out = r_op_count;
`else
    logic w_unused;
    assign w_unused = w_rsp_done;
`endif

endmodule
